// File: rtl/vshift_sequencer_pkg.sv
// Shared vector definitions: vsew codes, chunk size, sequencer states.
// Also hosts the scalar splat helper used at instruction accept.
package vshift_sequencer_pkg;

  localparam int CHUNK_W     = 128;
  localparam int CHUNK_BYTES = 16;

  localparam logic [2:0] VSEW_8  = 3'b000;
  localparam logic [2:0] VSEW_16 = 3'b001;
  localparam logic [2:0] VSEW_32 = 3'b010;
  localparam logic [2:0] VSEW_64 = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [CHUNK_W-1:0] a;
    logic [CHUNK_W-1:0] b;
  } opnd_t;

  // Low SEW bits of the scalar replicated across one chunk.
  function automatic logic [CHUNK_W-1:0] splat(
    input logic [63:0] s,
    input logic [2:0]  vsew
  );
    logic [CHUNK_W-1:0] r;
    r = '0;
    case (vsew)
      VSEW_8:  r = {16{s[7:0]}};
      VSEW_16: r = {8{s[15:0]}};
      VSEW_32: r = {4{s[31:0]}};
      VSEW_64: r = {2{s[63:0]}};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vshift_opfifo.sv
// Two-entry operand FIFO between VRF read return and the shift unit.
// Ports: push_i/data_i in, pop_i/data_o out, count_o occupancy (0..2).
module vshift_opfifo #(
  parameter int W = 256
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem [2];
  logic         wp;
  logic         rp;
  logic [1:0]   cnt;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push_i) begin
        mem[wp] <= data_i;
        wp      <= ~wp;
      end
      if (pop_i) rp <= ~rp;
      unique case ({push_i, pop_i})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign data_o  = mem[rp];
  assign count_o = cnt;

endmodule

// File: rtl/vshift_sequencer.sv
// Sequences one vector shift over VLEN bits, one 128-bit chunk per step.
// Ports: req_* instruction in, rd_* VRF reads, sh_* shift unit, wb_* writeback.
module vshift_sequencer
  import vshift_sequencer_pkg::*;
#(
  parameter int VLEN = 1024,
  parameter int CH_W = 3,
  parameter int VL_W = 8
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_vsew_i,
  input  logic [VL_W-1:0] req_vl_i,
  input  logic [4:0]      req_vs2_i,
  input  logic [4:0]      req_vs1_i,
  input  logic [4:0]      req_vd_i,
  input  logic            req_scalar_en_i,
  input  logic [63:0]     req_scalar_i,
  output logic            rd_en_o,
  output logic [4:0]      rd_reg_a_o,
  output logic [4:0]      rd_reg_b_o,
  output logic [CH_W-1:0] rd_chunk_o,
  input  logic [127:0]    rd_data_a_i,
  input  logic [127:0]    rd_data_b_i,
  output logic [2:0]      sh_vsew_o,
  output logic [127:0]    sh_a_o,
  output logic [127:0]    sh_b_o,
  input  logic [127:0]    sh_s_i,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [4:0]      wb_reg_o,
  output logic [CH_W-1:0] wb_chunk_o,
  output logic [127:0]    wb_data_o,
  output logic [15:0]     wb_be_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o
);

  localparam int TB_W = $clog2(VLEN/8 + 1);
  localparam int NC_W = TB_W - 3;
  localparam logic [VL_W-1:0] VLMAX8 = VL_W'(VLEN/8);

  state_t state_q;
  state_t state_d;

  logic            accept;
  logic            bad_sew;
  logic            rd_en;
  logic            rd_pending;
  logic            pop;
  logic            credit_ok;
  logic            last_issue;
  logic            fifo_nempty;
  logic [1:0]      fifo_cnt;
  opnd_t           fifo_in;
  opnd_t           fifo_out;

  logic [2:0]      vsew_q;
  logic [4:0]      vs1_q;
  logic [4:0]      vs2_q;
  logic [4:0]      vd_q;
  logic            scal_en_q;
  logic            err_q;
  logic [127:0]    splat_q;

  logic [VL_W-1:0] vlmax;
  logic [VL_W-1:0] vl_c;
  logic [TB_W-1:0] total_d;
  logic [TB_W-1:0] total_q;
  logic [TB_W-1:0] rem;
  logic [NC_W-1:0] nch_d;
  logic [NC_W-1:0] nch_q;
  logic [NC_W-1:0] issue_cnt;
  logic [CH_W-1:0] pop_cnt;
  logic [15:0]     be_d;

  assign accept  = req_valid_i && req_ready_o;
  assign bad_sew = req_vsew_i[2];

  // Work size from the incoming request.
  always_comb begin
    vlmax   = VLMAX8 >> req_vsew_i[1:0];
    vl_c    = (req_vl_i > vlmax) ? vlmax : req_vl_i;
    total_d = TB_W'({3'b000, vl_c} << req_vsew_i[1:0]);
    nch_d   = NC_W'(({1'b0, total_d}
            + (TB_W+1)'(CHUNK_BYTES-1)) >> 4);
  end

  // Tail mask for the chunk being popped.
  always_comb begin
    rem  = total_q - TB_W'({pop_cnt, 4'b0000});
    be_d = (rem >= TB_W'(CHUNK_BYTES)) ? 16'hFFFF
         : (16'h0001 << rem[3:0]) - 16'h0001;
  end

  assign fifo_nempty = fifo_cnt != 2'd0;
  assign pop         = fifo_nempty && (!wb_valid_o || wb_ready_i);
  assign last_issue  = issue_cnt == nch_q - NC_W'(1);

  // Reads in flight plus buffered must stay within the two FIFO slots.
  assign credit_ok = ({1'b0, fifo_cnt} + {2'b00, rd_pending})
                   < (3'd2 + {2'b00, pop});

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (accept)
          state_d = (bad_sew || req_vl_i == '0) ? ST_DONE : ST_RUN;
      ST_RUN:
        if (rd_en && last_issue) state_d = ST_DRAIN;
      ST_DRAIN:
        if (!fifo_nempty && !rd_pending && wb_valid_o && wb_ready_i)
          state_d = ST_DONE;
      ST_DONE:
        state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    err_o       = 1'b0;
    rd_en       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
      end
      ST_RUN:   rd_en = credit_ok;
      ST_DRAIN: rd_en = 1'b0;
      ST_DONE: begin
        done_o = 1'b1;
        err_o  = err_q;
      end
      default:  busy_o = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vsew_q     <= '0;
      vs1_q      <= '0;
      vs2_q      <= '0;
      vd_q       <= '0;
      scal_en_q  <= 1'b0;
      err_q      <= 1'b0;
      splat_q    <= '0;
      total_q    <= '0;
      nch_q      <= '0;
      issue_cnt  <= '0;
      pop_cnt    <= '0;
      rd_pending <= 1'b0;
    end else begin
      rd_pending <= rd_en;
      if (accept) begin
        vsew_q    <= req_vsew_i;
        vs1_q     <= req_vs1_i;
        vs2_q     <= req_vs2_i;
        vd_q      <= req_vd_i;
        scal_en_q <= req_scalar_en_i;
        err_q     <= bad_sew;
        splat_q   <= splat(req_scalar_i, req_vsew_i);
        total_q   <= total_d;
        nch_q     <= nch_d;
        issue_cnt <= '0;
        pop_cnt   <= '0;
      end else begin
        if (rd_en) issue_cnt <= issue_cnt + NC_W'(1);
        if (pop)   pop_cnt   <= pop_cnt + CH_W'(1);
      end
    end
  end

  // Writeback register: reload on pop, hold while stalled.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wb_valid_o <= 1'b0;
      wb_data_o  <= '0;
      wb_chunk_o <= '0;
      wb_be_o    <= '0;
    end else if (pop) begin
      wb_valid_o <= 1'b1;
      wb_data_o  <= sh_s_i;
      wb_chunk_o <= pop_cnt;
      wb_be_o    <= be_d;
    end else if (wb_ready_i) begin
      wb_valid_o <= 1'b0;
    end
  end

  assign fifo_in.a = rd_data_a_i;
  assign fifo_in.b = rd_data_b_i;

  vshift_opfifo #(
    .W($bits(opnd_t))
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (rd_pending),
    .data_i  (fifo_in),
    .pop_i   (pop),
    .data_o  (fifo_out),
    .count_o (fifo_cnt)
  );

  assign rd_en_o    = rd_en;
  assign rd_reg_a_o = vs2_q;
  assign rd_reg_b_o = vs1_q;
  assign rd_chunk_o = rd_en ? issue_cnt[CH_W-1:0] : '0;

  assign sh_vsew_o = vsew_q;
  assign sh_a_o    = fifo_nempty ? fifo_out.a : '0;
  assign sh_b_o    = !fifo_nempty ? '0
                   : scal_en_q ? splat_q : fifo_out.b;
  assign wb_reg_o  = vd_q;

endmodule

// File: tb/tb_vshift_sequencer.sv
// Directed bench for vshift_sequencer: VRF and shift-unit models,
// table of instructions plus backpressure and mid-run reset sequences.
module tb_vshift_sequencer;

  logic         clk_i = 1'b0;
  logic         rstn_i;
  logic         req_valid_i;
  logic         req_ready_o;
  logic [2:0]   req_vsew_i;
  logic [7:0]   req_vl_i;
  logic [4:0]   req_vs2_i;
  logic [4:0]   req_vs1_i;
  logic [4:0]   req_vd_i;
  logic         req_scalar_en_i;
  logic [63:0]  req_scalar_i;
  logic         rd_en_o;
  logic [4:0]   rd_reg_a_o;
  logic [4:0]   rd_reg_b_o;
  logic [2:0]   rd_chunk_o;
  logic [127:0] rd_data_a_i = '0;
  logic [127:0] rd_data_b_i = '0;
  logic [2:0]   sh_vsew_o;
  logic [127:0] sh_a_o;
  logic [127:0] sh_b_o;
  logic [127:0] sh_s_i;
  logic         wb_valid_o;
  logic         wb_ready_i;
  logic [4:0]   wb_reg_o;
  logic [2:0]   wb_chunk_o;
  logic [127:0] wb_data_o;
  logic [15:0]  wb_be_o;
  logic         busy_o;
  logic         done_o;
  logic         err_o;

  always #5 clk_i = ~clk_i;

  vshift_sequencer dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_vsew_i      (req_vsew_i),
    .req_vl_i        (req_vl_i),
    .req_vs2_i       (req_vs2_i),
    .req_vs1_i       (req_vs1_i),
    .req_vd_i        (req_vd_i),
    .req_scalar_en_i (req_scalar_en_i),
    .req_scalar_i    (req_scalar_i),
    .rd_en_o         (rd_en_o),
    .rd_reg_a_o      (rd_reg_a_o),
    .rd_reg_b_o      (rd_reg_b_o),
    .rd_chunk_o      (rd_chunk_o),
    .rd_data_a_i     (rd_data_a_i),
    .rd_data_b_i     (rd_data_b_i),
    .sh_vsew_o       (sh_vsew_o),
    .sh_a_o          (sh_a_o),
    .sh_b_o          (sh_b_o),
    .sh_s_i          (sh_s_i),
    .wb_valid_o      (wb_valid_o),
    .wb_ready_i      (wb_ready_i),
    .wb_reg_o        (wb_reg_o),
    .wb_chunk_o      (wb_chunk_o),
    .wb_data_o       (wb_data_o),
    .wb_be_o         (wb_be_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .err_o           (err_o)
  );

  typedef struct {
    logic [2:0]   vsew;
    logic [7:0]   vl;
    logic [4:0]   vs2;
    logic [4:0]   vs1;
    logic [4:0]   vd;
    logic         sc_en;
    logic [63:0]  sc;
    int           nch;
    logic [15:0]  last_be;
    logic         err;
    int           lat;
    logic         chk_shb;
    logic [127:0] shb;
  } vec_t;

  vec_t         tbl[9];
  vec_t         cur;
  logic [127:0] vrf[32][8];
  logic [151:0] expq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_t, rd_t0, wb_t0, done_t, n_rd, n_wb;
  logic         done_seen, err_seen, prev_stall;
  logic [15:0]  last_be;
  logic [127:0] shb_seen;
  logic [152:0] prev_wb;

  function automatic logic [127:0] sh_model(
    input logic [127:0] a, input logic [127:0] b, input logic [2:0] vsew);
    logic [127:0] r;
    r = '0;
    case (vsew)
      3'd0: for (int i = 0; i < 16; i++)
              r[i*8 +: 8] = a[i*8 +: 8] << b[i*8 +: 3];
      3'd1: for (int i = 0; i < 8; i++)
              r[i*16 +: 16] = a[i*16 +: 16] << b[i*16 +: 4];
      3'd2: for (int i = 0; i < 4; i++)
              r[i*32 +: 32] = a[i*32 +: 32] << b[i*32 +: 5];
      3'd3: for (int i = 0; i < 2; i++)
              r[i*64 +: 64] = a[i*64 +: 64] << b[i*64 +: 6];
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [127:0] tb_splat(
    input logic [63:0] s, input logic [2:0] vsew);
    logic [127:0] r;
    int w;
    w = 8 << vsew;
    for (int i = 0; i < 128; i++) r[i] = s[i % w];
    return r;
  endfunction

  task automatic check(input string name,
                       input logic [159:0] act,
                       input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always_comb sh_s_i = sh_model(sh_a_o, sh_b_o, sh_vsew_o);

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (rd_en_o) begin
      rd_data_a_i <= vrf[rd_reg_a_o][rd_chunk_o];
      rd_data_b_i <= vrf[rd_reg_b_o][rd_chunk_o];
    end
  end

  always @(negedge clk_i) begin
    if (rstn_i) begin
      if (req_valid_i && req_ready_o) acc_t = cyc;
      if (busy_o)
        check("outstanding",
              32'((n_rd - n_wb - int'(wb_valid_o)) <= 2), 1);
      if (rd_en_o) begin
        if (n_rd == 0) rd_t0 = cyc;
        check("rd_issue", {rd_reg_a_o, rd_reg_b_o, rd_chunk_o},
              {cur.vs2, cur.vs1, 3'(n_rd)});
        n_rd++;
      end
      if (wb_valid_o && wb_t0 < 0) wb_t0 = cyc;
      if (prev_stall)
        check("wb_hold", {wb_valid_o, wb_reg_o, wb_chunk_o,
                          wb_be_o, wb_data_o}, prev_wb);
      prev_stall = wb_valid_o && !wb_ready_i;
      prev_wb = {wb_valid_o, wb_reg_o, wb_chunk_o, wb_be_o, wb_data_o};
      if (wb_valid_o && wb_ready_i) begin
        if (expq.size() > 0)
          check("wb_data", {wb_reg_o, wb_chunk_o, wb_be_o, wb_data_o},
                expq.pop_front());
        last_be = wb_be_o;
        n_wb++;
      end
      if (cyc == acc_t + 3) shb_seen = sh_b_o;
      if (done_o) begin
        done_seen = 1'b1;
        done_t    = cyc;
        err_seen  = err_o;
      end
    end
  end

  task automatic launch(input vec_t v);
    logic [127:0] b;
    logic [15:0]  be;
    expq.delete();
    n_rd = 0; n_wb = 0; rd_t0 = -1; wb_t0 = -1; done_t = -1;
    acc_t = -100; done_seen = 1'b0; err_seen = 1'b0;
    prev_stall = 1'b0; last_be = '0; shb_seen = '0;
    cur = v;
    for (int k = 0; k < v.nch; k++) begin
      b  = v.sc_en ? tb_splat(v.sc, v.vsew) : vrf[v.vs1][k];
      be = (k == v.nch - 1) ? v.last_be : 16'hFFFF;
      expq.push_back({v.vd, 3'(k), be,
                      sh_model(vrf[v.vs2][k], b, v.vsew)});
    end
    req_vsew_i      = v.vsew;
    req_vl_i        = v.vl;
    req_vs2_i       = v.vs2;
    req_vs1_i       = v.vs1;
    req_vd_i        = v.vd;
    req_scalar_en_i = v.sc_en;
    req_scalar_i    = v.sc;
    req_valid_i     = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_done(input vec_t v, input int stall);
    int n;
    n = 0;
    if (stall > 0) begin
      while (!wb_valid_o && n < 50) begin
        @(posedge clk_i); #1; n++;
      end
      wb_ready_i = 1'b0;
      repeat (stall) @(posedge clk_i);
      #1;
      wb_ready_i = 1'b1;
    end
    n = 0;
    while (!done_seen && n < 300) begin
      @(posedge clk_i); n++;
    end
    check("done_seen", 160'(done_seen), 1);
    check("n_rd", n_rd, v.nch);
    check("n_wb", n_wb, v.nch);
    check("last_be", last_be, v.last_be);
    check("err", 160'(err_seen), 160'(v.err));
    if (stall == 0) begin
      check("done_lat", done_t - acc_t, v.lat);
      if (v.nch > 0) begin
        check("rd_lat", rd_t0 - acc_t, 1);
        check("wb_lat", wb_t0 - acc_t, 4);
      end
    end
    if (v.chk_shb) check("sh_b", shb_seen, v.shb);
    @(posedge clk_i); #1;
    check("idle", {req_ready_o, busy_o, done_o}, 3'b100);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ctl"},
          {req_ready_o, rd_en_o, wb_valid_o, done_o, err_o, busy_o,
           rd_chunk_o, wb_chunk_o, wb_be_o, wb_reg_o, sh_vsew_o,
           rd_reg_a_o, rd_reg_b_o},
          {1'b1, 5'b0, 3'd0, 3'd0, 16'h0, 5'd0, 3'd0, 5'd0, 5'd0});
    check({tag, "_wbd"}, wb_data_o, 0);
    check({tag, "_sh"}, sh_a_o | sh_b_o, 0);
  endtask

  initial begin
    int n;
    for (int r = 0; r < 32; r++)
      for (int k = 0; k < 8; k++)
        vrf[r][k] = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 8; k++) begin
      vrf[1][k] = {4{32'h1}};
      vrf[2][k] = {4{32'h1}};
    end
    tbl[0] = '{3'd0, 8'd128, 5'd3, 5'd4, 5'd5, 1'b0, 64'd0,
               8, 16'hFFFF, 1'b0, 12, 1'b0, 128'd0};
    tbl[1] = '{3'd2, 8'd10, 5'd1, 5'd2, 5'd6, 1'b0, 64'd0,
               3, 16'h00FF, 1'b0, 7, 1'b1, {4{32'h1}}};
    tbl[2] = '{3'd1, 8'd8, 5'd7, 5'd9, 5'd8, 1'b1, 64'h3,
               1, 16'hFFFF, 1'b0, 5, 1'b1, {8{16'h0003}}};
    tbl[3] = '{3'd3, 8'd16, 5'd10, 5'd11, 5'd12, 1'b0, 64'd0,
               8, 16'hFFFF, 1'b0, 12, 1'b0, 128'd0};
    tbl[4] = '{3'd0, 8'd17, 5'd13, 5'd14, 5'd15, 1'b0, 64'd0,
               2, 16'h0001, 1'b0, 6, 1'b0, 128'd0};
    tbl[5] = '{3'd1, 8'd0, 5'd3, 5'd4, 5'd21, 1'b0, 64'd0,
               0, 16'h0000, 1'b0, 1, 1'b0, 128'd0};
    tbl[6] = '{3'd7, 8'd5, 5'd3, 5'd4, 5'd22, 1'b0, 64'd0,
               0, 16'h0000, 1'b1, 1, 1'b0, 128'd0};
    tbl[7] = '{3'd1, 8'd3, 5'd16, 5'd4, 5'd17, 1'b1,
               64'hDEAD_0000_0001_2345,
               1, 16'h003F, 1'b0, 5, 1'b1, {8{16'h2345}}};
    tbl[8] = '{3'd3, 8'd200, 5'd18, 5'd19, 5'd20, 1'b0, 64'd0,
               8, 16'hFFFF, 1'b0, 12, 1'b0, 128'd0};

    rstn_i = 1'b0;
    req_valid_i = 1'b0;
    req_vsew_i = '0; req_vl_i = '0;
    req_vs2_i = '0; req_vs1_i = '0; req_vd_i = '0;
    req_scalar_en_i = 1'b0; req_scalar_i = '0;
    wb_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_outs("reset");
    rstn_i = 1'b1;
    @(posedge clk_i); #1;

    for (int i = 0; i < 9; i++) begin
      launch(tbl[i]);
      wait_done(tbl[i], 0);
    end

    launch(tbl[3]);
    wait_done(tbl[3], 5);

    launch(tbl[0]);
    n = 0;
    while (n_rd < 3 && n < 20) begin
      @(posedge clk_i); #1; n++;
    end
    check("mid_reads", 160'(n_rd >= 3), 1);
    rstn_i = 1'b0;
    #1;
    check_reset_outs("mid_rst");
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    @(posedge clk_i); #1;
    check("post_rst_ready", {req_ready_o, busy_o}, 2'b10);
    launch(tbl[1]);
    wait_done(tbl[1], 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
